// File: rtl/uart_rx_fifo_if.sv
// Receive-side FIFO bus: receiver strobes in, FWFT valid/ready out, status.
// Stats signals exist only when UART_RX_FIFO_STATS_EN is defined.
interface uart_rx_fifo_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_error;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [AW:0] count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        ovf_clr;
`ifdef UART_RX_FIFO_STATS_EN
    logic [15:0] frame_err_cnt;
    logic [15:0] drop_cnt;
    logic        stats_clr;
`endif

    // Receiver/consumer side
    modport master (
        output in_data, in_valid, in_error, out_ready, ovf_clr,
`ifdef UART_RX_FIFO_STATS_EN
        output stats_clr,
        input  frame_err_cnt, drop_cnt,
`endif
        input  out_data, out_valid, count, full, empty, overflow
    );

    // FIFO side
    modport slave (
        input  in_data, in_valid, in_error, out_ready, ovf_clr,
`ifdef UART_RX_FIFO_STATS_EN
        input  stats_clr,
        output frame_err_cnt, drop_cnt,
`endif
        output out_data, out_valid, count, full, empty, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO: non-stallable push, FWFT pop, sticky overflow.
// Optional saturating frame-error/drop counters under UART_RX_FIFO_STATS_EN.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst_,
    uart_rx_fifo_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        ovf_q, ovf_d;
    logic        empty_c, full_c, pop_c, push_c, drop_c;

    // Extra pointer MSB separates full from empty when the indices match
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_c   = !empty_c && bus.out_ready;
    assign push_c  = bus.in_valid && (!full_c || pop_c);
    assign drop_c  = bus.in_valid && full_c && !pop_c;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (push_c) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        if (drop_c)           ovf_d = 1'b1;
        else if (bus.ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is intentionally left unreset
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q[AW-1:0]] <= bus.in_data;
    end

    assign bus.out_data  = empty_c ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign bus.out_valid = !empty_c;
    assign bus.count     = wr_ptr_q - rd_ptr_q;
    assign bus.full      = full_c;
    assign bus.empty     = empty_c;
    assign bus.overflow  = ovf_q;

`ifdef UART_RX_FIFO_STATS_EN
    logic [15:0] ferr_q, ferr_d;
    logic [15:0] drop_q, drop_d;

    // Saturating counters; a clear coinciding with an event leaves 1
    always_comb begin
        ferr_d = ferr_q;
        drop_d = drop_q;
        if (bus.stats_clr)                      ferr_d = 16'(bus.in_error);
        else if (bus.in_error && ferr_q != 16'hFFFF) ferr_d = ferr_q + 16'd1;
        if (bus.stats_clr)                      drop_d = 16'(drop_c);
        else if (drop_c && drop_q != 16'hFFFF)  drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ferr_q <= '0;
            drop_q <= '0;
        end else begin
            ferr_q <= ferr_d;
            drop_q <= drop_d;
        end
    end

    assign bus.frame_err_cnt = ferr_q;
    assign bus.drop_cnt      = drop_q;
`else
    logic unused_in_error;
    assign unused_in_error = bus.in_error;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed, table-driven bench for uart_rx_fifo (DEPTH=16).
module tb_uart_rx_fifo;
    localparam int unsigned DEPTH = 16;

    logic clk;
    logic rst_;
    int   checks;
    int   failures;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       rdy;
        logic       err;
        logic       clr;
        int         ec;
        logic [7:0] ed;
        logic       eo;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic iv, input logic [7:0] d, input logic rdy,
                                input logic err, input logic clr, input int ec,
                                input logic [7:0] ed, input logic eo);
        vec_t v;
        v.iv = iv; v.d = d; v.rdy = rdy; v.err = err; v.clr = clr;
        v.ec = ec; v.ed = ed; v.eo = eo;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_status(input string tag, input int ec, input logic [7:0] ed, input logic eo);
        chk({tag, " count"},     int'(bus.count), ec);
        chk({tag, " out_data"},  int'(bus.out_data), int'(ed));
        chk({tag, " out_valid"}, int'(bus.out_valid), int'(ec != 0));
        chk({tag, " empty"},     int'(bus.empty), int'(ec == 0));
        chk({tag, " full"},      int'(bus.full), int'(ec == int'(DEPTH)));
        chk({tag, " overflow"},  int'(bus.overflow), int'(eo));
    endtask

    task automatic drive(input logic iv, input logic [7:0] d, input logic rdy,
                         input logic err, input logic clr);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = rdy;
        bus.in_error  = err;
        bus.ovf_clr   = clr;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_ = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_STATS_EN
        bus.stats_clr = 1'b0;
`endif

        // Build the vector table
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0);
        add(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1, 8'hA5, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) add(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, i + 1, 8'h00, 1'b0);
        add(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 16, 8'h00, 1'b1);
        add(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 16, 8'h01, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16, 8'h01, 1'b0);
        for (int j = 1; j <= 16; j++)
            add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16 - j,
                (j < 15) ? 8'(j + 1) : ((j == 15) ? 8'h77 : 8'h00), 1'b0);
        // Streaming with out_ready held high; first push lands in an empty FIFO
        for (int i = 0; i < 48; i++)
            add(1'b1, 8'(8'h30 + i), 1'b1, 1'b0, 1'b0, 1, 8'(8'h30 + i), 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) add(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0, i + 1, 8'h80, 1'b0);
        add(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 16, 8'h80, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16, 8'h80, 1'b0);
        for (int j = 1; j <= 16; j++)
            add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16 - j, (j < 16) ? 8'(8'h80 + j) : 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0);
        add(1'b1, 8'h5C, 1'b0, 1'b1, 1'b0, 1, 8'h5C, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0);

        // Reset state
        step();
        step();
        chk_status("reset", 0, 8'h00, 1'b0);
`ifdef UART_RX_FIFO_STATS_EN
        chk("reset frame_err_cnt", int'(bus.frame_err_cnt), 0);
        chk("reset drop_cnt", int'(bus.drop_cnt), 0);
`endif
        rst_ = 1'b1;

        foreach (vq[k]) begin
            drive(vq[k].iv, vq[k].d, vq[k].rdy, vq[k].err, vq[k].clr);
            step();
            chk_status($sformatf("vec%0d", k), vq[k].ec, vq[k].ed, vq[k].eo);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

`ifdef UART_RX_FIFO_STATS_EN
        chk("frame_err_cnt", int'(bus.frame_err_cnt), 4);
        chk("drop_cnt", int'(bus.drop_cnt), 2);
        bus.stats_clr = 1'b1;
        bus.in_error  = 1'b1;
        step();
        bus.stats_clr = 1'b0;
        bus.in_error  = 1'b0;
        chk("clr+err frame_err_cnt", int'(bus.frame_err_cnt), 1);
        chk("clr drop_cnt", int'(bus.drop_cnt), 0);
`endif

        // Asynchronous reset with five bytes buffered
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk_status("pre-reset", 5, 8'hB0, 1'b0);
        #2 rst_ = 1'b0;
        #1 chk_status("async reset", 0, 8'h00, 1'b0);
`ifdef UART_RX_FIFO_STATS_EN
        chk("async reset frame_err_cnt", int'(bus.frame_err_cnt), 0);
`endif
        step();
        rst_ = 1'b1;
        drive(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        step();
        chk_status("post-reset push", 1, 8'hC3, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step();
        chk_status("post-reset pop", 0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
